// File: rtl/bcd_alu_sequencer.sv
// Digit-serial BCD add/subtract sequencer: one shared per-digit adder walked LSD->MSD by an FSM.
// Optional operand validity check enabled by defining BCD_CHECK_EN (adds the err port).
module bcd_alu_sequencer #(
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  sign,
`ifdef BCD_CHECK_EN
  output logic                  err,
`endif
  output logic                  overflow
);

  localparam int W  = 4*DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RUN, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d, sh_q, sh_d, result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d, c_q, c_d, psign_q, psign_d;
  logic            sign_q, sign_d, ovf_q, ovf_d;
  logic            bad, last;
  logic [4:0]      sum5;
  logic [5:0]      diff6;
  logic [3:0]      dig;
  logic            cout;
`ifdef BCD_CHECK_EN
  logic            err_q, err_d;
`endif

  // Any nibble above 9 in either operand makes the request invalid.
  always_comb begin
    bad = 1'b0;
`ifdef BCD_CHECK_EN
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
`endif
  end

  assign last = (cnt_q == CW'(DIGITS-1));

  // Shared digit slice: operands shift right so the active digit is always in [3:0].
  always_comb begin
    sum5  = 5'(x_q[3:0]) + 5'(y_q[3:0]) + 5'(c_q);
    diff6 = 6'(x_q[3:0]) - 6'(y_q[3:0]) - 6'(c_q);
    if (op_q) begin
      cout = diff6[5];
      dig  = cout ? 4'(diff6 + 6'd10) : diff6[3:0];
    end else begin
      cout = (sum5 > 5'd9);
      dig  = cout ? 4'(sum5 - 5'd10) : sum5[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = bad ? S_FIN : (op ? S_CMP : S_RUN);
      S_CMP:   state_d = S_RUN;
      S_RUN:   if (last) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CMP) || (state_q == S_RUN);
    done = (state_q == S_FIN);
  end

  always_comb begin
    x_d = x_q; y_d = y_q; sh_d = sh_q; cnt_d = cnt_q;
    op_d = op_q; c_d = c_q; psign_d = psign_q;
    result_d = result_q; sign_d = sign_q; ovf_d = ovf_q;
`ifdef BCD_CHECK_EN
    err_d = err_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        x_d = a; y_d = b; op_d = op;
        cnt_d = '0; c_d = 1'b0; psign_d = 1'b0;
`ifdef BCD_CHECK_EN
        if (bad) begin
          result_d = '0; sign_d = 1'b0; ovf_d = 1'b0; err_d = 1'b1;
        end
`endif
      end
      // Valid BCD orders the same as plain binary, so a wide unsigned compare suffices.
      S_CMP: if (x_q < y_q) begin
        x_d = y_q; y_d = x_q; psign_d = 1'b1;
      end
      S_RUN: begin
        x_d   = x_q >> 4;
        y_d   = y_q >> 4;
        c_d   = cout;
        sh_d  = {dig, sh_q[W-1:4]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          result_d = sh_d;
          sign_d   = op_q & psign_q;
          ovf_d    = ~op_q & cout;
`ifdef BCD_CHECK_EN
          err_d    = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0; y_q <= '0; sh_q <= '0; cnt_q <= '0;
      op_q <= 1'b0; c_q <= 1'b0; psign_q <= 1'b0;
      result_q <= '0; sign_q <= 1'b0; ovf_q <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      x_q <= x_d; y_q <= y_d; sh_q <= sh_d; cnt_q <= cnt_d;
      op_q <= op_d; c_q <= c_d; psign_q <= psign_d;
      result_q <= result_d; sign_q <= sign_d; ovf_q <= ovf_d;
`ifdef BCD_CHECK_EN
      err_q <= err_d;
`endif
    end
  end

  assign result   = result_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;
`ifdef BCD_CHECK_EN
  assign err      = err_q;
`endif

endmodule

// File: doc/bcd_alu_sequencer.md
# bcd_alu_sequencer

Multi-cycle controller that sequences digit-serial BCD addition and subtraction on the calculator's 40-bit, 10-digit operand buses. The state controller supplies S1/S2 and an operation code. This block latches them, walks the digits least-significant first with carry/borrow, and returns a magnitude plus sign for the display path. It replaces a wide combinational BCD adder with one shared per-digit adder/subtractor, advanced by the FSM.

## Interface
Parameters:
- `DIGITS`, default 10: number of BCD digits; operand/result width is 4*DIGITS.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  1  0 = add (a+b), 1 = subtract (a−b); latched with `start`.
- `a`  in  4*DIGITS  operand 1, BCD, latched with `start`.
- `b`  in  4*DIGITS  operand 2, BCD, latched with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  4*DIGITS  BCD magnitude; held until the next `done`.
- `sign`  out  1  1 = negative result.
- `overflow`  out  1  add carried out of the most-significant digit.
- `err`  out  1  invalid BCD operand; only exists when `BCD_CHECK_EN` is defined.

## Operation
- States: IDLE, CMP, RUN, FIN.
- IDLE:
  - On `start`=1, latch `a`, `b` and `op`, and clear the digit counter and carry/borrow.
  - `op`=0 goes to RUN; `op`=1 goes to CMP.
- CMP (one cycle): full-width magnitude compare.
  - If a ≥ b, the minuend is a, the subtrahend is b, and the pending sign is 0.
  - Otherwise the operands are swapped and the pending sign is 1.
- RUN: one digit per cycle, LSD to MSD, for exactly DIGITS cycles.
  - Add: s = x+y+c. If s > 9, the digit is s−10 and c=1; else the digit is s and c=0.
  - Sub: d = x−y−bw. If d < 0, the digit is d+10 and bw=1; else the digit is d and bw=0.
  - Digits shift into a result shift register from the top.
- FIN (one cycle):
  - Register `result`, `sign` and `overflow` (= final carry, add only; 0 for sub). Assert `done`, then return to IDLE.
- A zero subtraction result always has `sign`=0 (equal operands give a ≥ b).
- Add results are modulo 10^DIGITS when `overflow`=1.
- `start` outside IDLE (CMP, RUN, FIN) is ignored and not queued.
- Operand inputs may change freely after the `start` edge.
- `busy`=1 in CMP and RUN; `busy`=0 in IDLE and FIN.

## Timing
- `start` is sampled high at edge N.
- Add: RUN processes digits at edges N+1 … N+DIGITS. `done` is high for the cycle following edge N+DIGITS.
- Sub: one extra CMP cycle, so `done` is high for the cycle following edge N+DIGITS+1.
- `result`, `sign` and `overflow` change only on FIN entry, simultaneously with `done` rising.
- Back-to-back: the earliest next accepted `start` is the edge ending the FIN cycle's successor (IDLE).
- Reset is synchronous and takes priority over everything, including an operation in flight:
  - State goes to IDLE; `busy`=0, `done`=0, `result`=0, `sign`=0, `overflow`=0, `err`=0.
  - An aborted operation never produces `done`.

## Configuration
- `BCD_CHECK_EN` defined:
  - At the `start` edge, any nibble of `a` or `b` greater than 9 sends the FSM straight to FIN. `err`=1, `result`=0, `sign`=0, `overflow`=0.
  - `done` is high in the cycle after edge N.
  - `err` is cleared on the next valid FIN or on reset.
- `BCD_CHECK_EN` undefined:
  - There is no `err` port and no check.
  - Invalid nibbles pass through the same per-digit rules, truncated to 4 bits. The result is deterministic but not meaningful.

## Test plan
- Add, op=0, a=0000000123, b=0000000989 → `result`=0000001112, `sign`=0, `overflow`=0; `done` one cycle, 10 edges after `start`; `busy` high for 10 cycles.
- Sub, op=1, a=0000000100, b=0000000250 → `result`=0000000150, `sign`=1; `done` 11 edges after `start`.
- Add, a=9999999999, b=0000000001 → `result`=0000000000, `overflow`=1. Sub with a=b=0000004567 → `result`=0, `sign`=0.
- Pulse `start` with new operands during RUN → ignored; the first result is unchanged and exactly one `done` occurs.
- Assert `reset` on the 5th RUN cycle → all outputs 0 the next cycle and no `done`. A subsequent add 0000000005+0000000007 → 0000000012.
- With `BCD_CHECK_EN`, a=00000000A0, add → `err`=1, `result`=0, `done` in the cycle after `start`. A following valid add clears `err`.
